// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-Lite bus bundle between a single master and the memory slave.
// HREADY is the system-level ready that the fabric feeds back to every
// slave; here the system ties it to HREADYOUT.
// Handshake: an address phase is accepted on a rising edge where
// HSEL & HREADY & HTRANS[1]; its data phase completes on the first later
// edge where HREADY is high. HREADYOUT low stretches the current data phase.
interface ahb_lite_mem_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_mem_slave.sv
// Zero-wait-state AHB-Lite memory slave: little-endian 32-bit word RAM with
// byte/halfword/word access and a two-cycle ERROR response for illegal
// transfers (bad size, misalignment, out-of-range address).
// HRESETn is active-high despite its name.
module ahb_lite_mem_slave #(
    parameter int MEM_DEPTH = 256
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_lite_mem_slave_if.slave  bus,
    output logic [1:0]           o_dbg_state
);

    localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no data phase in progress
        ST_DATA = 2'd1,   // legal data phase, completes this cycle
        ST_ERR1 = 2'd2,   // first ERROR cycle (wait state)
        ST_ERR2 = 2'd3    // second ERROR cycle (ready)
    } state_t;

    state_t        r_state;
    logic          r_hreadyout;
    logic          r_hresp;
    logic [AW-1:0] r_idx;      // word index of the data phase
    logic [1:0]    r_bsel;     // byte offset within the word
    logic [1:0]    r_size;     // legal sizes only: 0 byte, 1 half, 2 word
    logic          r_write;
    logic [31:0]   r_mem [MEM_DEPTH];

    logic          w_sample;
    logic          w_illegal;
    logic [3:0]    w_lanes;
    logic [31:0]   w_lane_bits;
    logic [31:0]   w_rd_word;
    logic          w_unused_ok;

    assign w_sample  = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    assign w_illegal = (bus.HSIZE > 3'b010)
                     | ((bus.HSIZE == 3'b001) & bus.HADDR[0])
                     | ((bus.HSIZE == 3'b010) & (bus.HADDR[1:0] != 2'b00))
                     | (bus.HADDR >= MEM_BYTES);

    // Attribute-only inputs and HTRANS[0] do not affect behaviour.
    assign w_unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

    // Byte lanes touched by the registered data phase.
    always_comb begin
        w_lanes = 4'b0000;
        case (r_size)
            2'd0:    w_lanes[r_bsel] = 1'b1;
            2'd1:    w_lanes = r_bsel[1] ? 4'b1100 : 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
    end

    assign w_lane_bits = {{8{w_lanes[3]}}, {8{w_lanes[2]}},
                          {8{w_lanes[1]}}, {8{w_lanes[0]}}};
    assign w_rd_word   = r_mem[r_idx];

    // Transfer FSM: registers the address phase and the response outputs.
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_idx       <= '0;
            r_bsel      <= 2'b00;
            r_size      <= 2'b00;
            r_write     <= 1'b0;
        end else if (r_state == ST_ERR1) begin
            r_state     <= ST_ERR2;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b1;
        end else if (w_sample && !w_illegal) begin
            r_state     <= ST_DATA;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_idx       <= bus.HADDR[AW+1:2];
            r_bsel      <= bus.HADDR[1:0];
            r_size      <= bus.HSIZE[1:0];
            r_write     <= bus.HWRITE;
        end else if (w_sample) begin
            r_state     <= ST_ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b1;
            r_write     <= 1'b0;
        end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_write     <= 1'b0;
        end
    end

    // Memory array: cleared on reset, written lane-wise at the end of a write data phase.
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == ST_DATA && r_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lanes[b]) begin
                    r_mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign bus.HREADYOUT = r_hreadyout;
    assign bus.HRESP     = r_hresp;
    assign bus.HRDATA    = (r_state == ST_DATA && !r_write) ? (w_rd_word & w_lane_bits) : 32'h0;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: directed scenarios followed by random bus
// traffic, checked every cycle against a byte-level reference model.
module tb_ahb_lite_mem_slave;

    localparam int DEPTH  = 256;
    localparam int NBYTES = 4 * DEPTH;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [1:0] dbg_state;

    always #5 HCLK = ~HCLK;

    ahb_lite_mem_slave_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_lite_mem_slave #(.MEM_DEPTH(DEPTH)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // Reference model: byte memory plus the one outstanding data phase.
    typedef enum int {P_NONE, P_RD, P_WR, P_ERR1, P_ERR2} pend_t;

    logic [7:0]  m_bytes [NBYTES];
    pend_t       p_kind;
    int unsigned p_addr;
    int unsigned p_nbytes;
    bit          model_valid;

    int          n_checks;
    int          n_pass;
    logic [31:0] obs_rdata;
    logic        obs_ready;
    logic        obs_resp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One bus clock: drives an address phase (and HWDATA for the pending data
    // phase), checks the current data-phase response, then advances the model.
    task automatic bus_cycle(input logic rst, input logic sel, input logic [1:0] trans,
                             input logic wr, input logic [31:0] addr, input logic [2:0] size,
                             input logic [31:0] wdata);
        logic [31:0] e_rdata;
        logic        e_ready;
        logic        e_resp;
        int unsigned a;
        int unsigned nb;
        bit          legal;

        HRESETn       = rst;
        bus.HSEL      = sel;
        bus.HTRANS    = trans;
        bus.HWRITE    = wr;
        bus.HADDR     = addr;
        bus.HSIZE     = size;
        bus.HWDATA    = wdata;
        bus.HBURST    = 3'($urandom);
        bus.HPROT     = 4'($urandom);
        bus.HMASTLOCK = 1'($urandom);

        e_ready = (p_kind != P_ERR1);
        e_resp  = (p_kind == P_ERR1) || (p_kind == P_ERR2);
        e_rdata = 32'h0;
        if (p_kind == P_RD) begin
            for (int b = 0; b < 4; b++) begin
                a = (p_addr & ~32'd3) + b;
                if (a >= p_addr && a < p_addr + p_nbytes) e_rdata[8*b +: 8] = m_bytes[a];
            end
        end

        @(negedge HCLK);
        obs_rdata = bus.HRDATA;
        obs_ready = bus.HREADYOUT;
        obs_resp  = bus.HRESP;
        if (model_valid) begin
            check("hreadyout", {31'b0, obs_ready}, {31'b0, e_ready});
            check("hresp",     {31'b0, obs_resp},  {31'b0, e_resp});
            check("hrdata",    obs_rdata,          e_rdata);
        end

        if (rst) begin
            for (int i = 0; i < NBYTES; i++) m_bytes[i] = 8'h00;
            p_kind      = P_NONE;
            model_valid = 1'b1;
        end else begin
            if (p_kind == P_WR) begin
                for (int k = 0; k < int'(p_nbytes); k++) begin
                    a = p_addr + k;
                    m_bytes[a] = wdata[8*(a % 4) +: 8];
                end
            end
            if (p_kind == P_ERR1) begin
                p_kind = P_ERR2;
            end else if (sel && trans[1]) begin
                nb    = (size <= 3'd2) ? (32'd1 << size) : 32'd1;
                legal = (size <= 3'd2) && (addr % nb == 0) && (addr < NBYTES);
                p_kind   = legal ? (wr ? P_WR : P_RD) : P_ERR1;
                p_addr   = addr;
                p_nbytes = nb;
            end else begin
                p_kind = P_NONE;
            end
        end

        @(posedge HCLK);
        #1;
    endtask

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [2:0] S_B    = 3'b000;
    localparam logic [2:0] S_H    = 3'b001;
    localparam logic [2:0] S_W    = 3'b010;

    initial begin
        logic [31:0] r_addr;
        logic [2:0]  r_size;
        int unsigned nb;

        n_checks    = 0;
        n_pass      = 0;
        model_valid = 1'b0;
        p_kind      = P_NONE;
        p_addr      = 0;
        p_nbytes    = 1;
        HRESETn     = 1'b1;
        bus.HSEL = 1'b0; bus.HTRANS = T_IDLE; bus.HWRITE = 1'b0; bus.HADDR = '0;
        bus.HSIZE = S_W; bus.HWDATA = '0; bus.HBURST = '0; bus.HPROT = '0; bus.HMASTLOCK = 1'b0;
        @(posedge HCLK);
        #1;

        // Reset, then idle cycle showing reset outputs.
        bus_cycle(1, 0, T_IDLE, 0, 0, S_W, 0);
        bus_cycle(0, 0, T_IDLE, 0, 0, S_W, 0);
        check("rst_hrdata", obs_rdata, 32'h0);
        check("rst_ready",  {31'b0, obs_ready}, 32'd1);

        // Halfword write 0x00 = 0xAA, word read 0x00.
        bus_cycle(0, 1, T_NSEQ, 1, 32'h0, S_H, $urandom);
        bus_cycle(0, 1, T_NSEQ, 0, 32'h0, S_W, 32'h000000AA);
        bus_cycle(0, 1, T_NSEQ, 0, 32'h2, S_B, $urandom);
        check("hw_then_word_rd", obs_rdata, 32'h000000AA);
        // Byte read 0x02, byte write 0x02, word read 0x00.
        bus_cycle(0, 1, T_NSEQ, 1, 32'h2, S_B, $urandom);
        check("byte_rd_02", obs_rdata, 32'h0);
        bus_cycle(0, 1, T_NSEQ, 0, 32'h0, S_W, 32'h00550000);
        bus_cycle(0, 1, T_NSEQ, 1, 32'h4, S_W, $urandom);
        check("word_rd_00", obs_rdata, 32'h005500AA);
        // Pipelined write then read of 0x04.
        bus_cycle(0, 1, T_NSEQ, 0, 32'h4, S_W, 32'hDEADBEEF);
        bus_cycle(0, 1, T_NSEQ, 1, 32'h1, S_H, $urandom);
        check("b2b_rd_04", obs_rdata, 32'hDEADBEEF);
        check("b2b_ready", {31'b0, obs_ready}, 32'd1);
        // Misaligned halfword write and out-of-range word read: two ERROR responses.
        bus_cycle(0, 1, T_NSEQ, 0, 32'h400, S_W, $urandom);
        check("err1_ready", {31'b0, obs_ready}, 32'd0);
        check("err1_resp",  {31'b0, obs_resp},  32'd1);
        bus_cycle(0, 1, T_NSEQ, 0, 32'h400, S_W, $urandom);
        check("err2_ready", {31'b0, obs_ready}, 32'd1);
        check("err2_resp",  {31'b0, obs_resp},  32'd1);
        bus_cycle(0, 1, T_NSEQ, 0, 32'h0, S_W, $urandom);
        check("oor_err1_ready", {31'b0, obs_ready}, 32'd0);
        bus_cycle(0, 1, T_NSEQ, 0, 32'h0, S_W, $urandom);
        check("oor_err2_resp", {31'b0, obs_resp}, 32'd1);
        bus_cycle(0, 1, T_IDLE, 1, 32'h0, S_W, $urandom);
        check("after_err_rd_00", obs_rdata, 32'h005500AA);
        // IDLE write-looking cycle must not write.
        bus_cycle(0, 1, T_NSEQ, 0, 32'h0, S_W, 32'hFFFFFFFF);
        bus_cycle(0, 0, T_IDLE, 0, 32'h0, S_W, $urandom);
        check("idle_no_write", obs_rdata, 32'h005500AA);

        // Reset during a write data phase discards the write.
        bus_cycle(0, 1, T_NSEQ, 1, 32'h8, S_W, $urandom);
        bus_cycle(1, 0, T_IDLE, 0, 32'h0, S_W, 32'h12345678);
        bus_cycle(0, 1, T_NSEQ, 0, 32'h8, S_W, $urandom);
        bus_cycle(0, 0, T_IDLE, 0, 32'h0, S_W, $urandom);
        check("rst_mid_write", obs_rdata, 32'h0);

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            r_size = ($urandom_range(0, 19) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            case ($urandom_range(0, 19))
                0:       r_addr = $urandom;
                1, 2:    r_addr = 32'($urandom_range(NBYTES - 8, NBYTES + 8));
                default: r_addr = 32'($urandom_range(0, 47));
            endcase
            nb = (r_size <= 3'd2) ? (32'd1 << r_size) : 32'd1;
            if ($urandom_range(0, 9) < 7) r_addr = r_addr & ~(nb - 1);
            bus_cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
                      2'($urandom_range(0, 3)), 1'($urandom), r_addr, r_size, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
